// File: rtl/timer_dev_pkg.sv
// timer_dev shared definitions: word width, register offsets, CTRL bit
// positions, mode encodings and FSM state encodings.
// Optional feature macro: TIMER_AUTORELOAD_EN (enables MODE 1 auto-reload).
`ifndef F
`define F 31
`endif

package timer_dev_pkg;

  // Register word offsets (CPU address bits [3:2])
  localparam logic [1:0] AddrCtrl   = 2'd0;
  localparam logic [1:0] AddrPreset = 2'd1;
  localparam logic [1:0] AddrCount  = 2'd2;

  // CTRL bit positions
  localparam int unsigned CtrlEnBit   = 0;
  localparam int unsigned CtrlModeLsb = 1;
  localparam int unsigned CtrlModeMsb = 2;
  localparam int unsigned CtrlImBit   = 3;

  // Mode encodings; 2 and 3 behave as one-shot
  localparam logic [1:0] ModeOneShot = 2'd0;
  localparam logic [1:0] ModeReload  = 2'd1;

  // FSM state encodings
  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StLoad = 2'd1;
  localparam logic [1:0] StCnt  = 2'd2;
  localparam logic [1:0] StInt  = 2'd3;

  // Assemble the CTRL read word; unused upper bits read as zero
  function automatic logic [`F:0] ctrl_word(input logic en, input logic [1:0] mode,
                                            input logic im);
    logic [`F:0] w;
    w = '0;
    w[CtrlEnBit]                 = en;
    w[CtrlModeMsb:CtrlModeLsb]   = mode;
    w[CtrlImBit]                 = im;
    return w;
  endfunction

endpackage

// File: rtl/timer_dev_if.sv
// timer_dev peripheral bus: CPU load/store access to the timer registers.
// Optional feature macro used by this block: TIMER_AUTORELOAD_EN.
`ifndef F
`define F 31
`endif

interface timer_dev_if;
  logic [1:0]  addr;
  logic        we;
  logic [`F:0] din;
  logic [`F:0] dout;

  modport master (output addr, output we, output din, input dout);
  modport slave  (input addr, input we, input din, output dout);
endinterface

// File: rtl/timer_dev.sv
// timer_dev: memory-mapped countdown timer with interrupt request to CP0.
// Registers: CTRL (EN, MODE, IM), PRESET (reload value), COUNT (read-only).
// Optional feature macro: TIMER_AUTORELOAD_EN. When undefined, MODE is not
// stored, reads as 0, and every expiry is one-shot.
`ifndef F
`define F 31
`endif

module timer_dev
  import timer_dev_pkg::*;
(
  input  logic     clk,
  input  logic     reset,
  timer_dev_if.slave bus,
  output logic     irq
);

  logic [1:0]  state_q, state_d;
  logic        en_q, en_d;
  logic        im_q, im_d;
  logic [`F:0] preset_q, preset_d;
  logic [`F:0] count_q, count_d;
  logic        flag_q, flag_d;
  logic        irq_q;
  logic        ctrl_wr, preset_wr, expire, reload_mode;
  logic [1:0]  mode_rd;

`ifdef TIMER_AUTORELOAD_EN
  logic [1:0] mode_q, mode_d;
  assign reload_mode = (mode_q == ModeReload);
  assign mode_rd     = mode_q;
`else
  assign reload_mode = 1'b0;
  assign mode_rd     = ModeOneShot;
  logic  unused_mode;
  assign unused_mode = ^{bus.din[CtrlModeMsb:CtrlModeLsb], ModeReload};
`endif

  logic  unused_din;
  assign unused_din = ^bus.din[`F:CtrlImBit+1];

  assign ctrl_wr   = bus.we && (bus.addr == AddrCtrl);
  assign preset_wr = bus.we && (bus.addr == AddrPreset);

  // Next-state: FSM first, then CPU writes override, then expiry sets the flag
  always_comb begin
    state_d  = state_q;
    en_d     = en_q;
    im_d     = im_q;
    preset_d = preset_q;
    count_d  = count_q;
    flag_d   = flag_q;
    expire   = 1'b0;
`ifdef TIMER_AUTORELOAD_EN
    mode_d   = mode_q;
`endif
    case (state_q)
      StIdle: begin
        if (en_q) state_d = StLoad;
      end
      StLoad: begin
        count_d = preset_q;
        state_d = StCnt;
      end
      StCnt: begin
        if (!en_q) begin
          state_d = StIdle;
        end else if (count_q > `F'(1)) begin
          count_d = count_q - `F'(1);
        end else begin
          count_d = '0;
          expire  = 1'b1;
          state_d = StInt;
        end
      end
      StInt: begin
        if (reload_mode) begin
          flag_d  = 1'b0;
          state_d = StLoad;
        end else begin
          en_d    = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // CPU write wins over the INT-state EN clear
    if (ctrl_wr) begin
      en_d   = bus.din[CtrlEnBit];
      im_d   = bus.din[CtrlImBit];
      flag_d = 1'b0;
`ifdef TIMER_AUTORELOAD_EN
      mode_d = bus.din[CtrlModeMsb:CtrlModeLsb];
`endif
    end
    if (preset_wr) preset_d = bus.din;
    // Expiry on the same edge as a CTRL write still leaves the flag set
    if (expire) flag_d = 1'b1;
  end

  // State and register update with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      en_q     <= 1'b0;
      im_q     <= 1'b0;
      preset_q <= '0;
      count_q  <= '0;
      flag_q   <= 1'b0;
      irq_q    <= 1'b0;
`ifdef TIMER_AUTORELOAD_EN
      mode_q   <= ModeOneShot;
`endif
    end else begin
      state_q  <= state_d;
      en_q     <= en_d;
      im_q     <= im_d;
      preset_q <= preset_d;
      count_q  <= count_d;
      flag_q   <= flag_d;
      // Registered from next values so irq rises on the expiry edge itself
      irq_q    <= flag_d & im_d;
`ifdef TIMER_AUTORELOAD_EN
      mode_q   <= mode_d;
`endif
    end
  end

  assign irq = irq_q;

  // Combinational read mux
  always_comb begin
    bus.dout = '0;
    case (bus.addr)
      AddrCtrl:   bus.dout = ctrl_word(en_q, mode_rd, im_q);
      AddrPreset: bus.dout = preset_q;
      AddrCount:  bus.dout = count_q;
      default:    bus.dout = '0;
    endcase
  end

endmodule

// File: tb/tb_timer_dev.sv
// Directed self-checking bench for timer_dev. Mode-1 expectations follow
// TIMER_AUTORELOAD_EN so the same bench covers both builds.
module tb_timer_dev;

  logic clk;
  logic reset;
  logic irq;
  int   n_total;
  int   n_bad;

  timer_dev_if bus ();

  timer_dev dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus),
    .irq  (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tickn(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus.addr = a;
    bus.din  = d;
    bus.we   = 1'b1;
    tick();
    bus.we   = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [1:0] a, input logic [31:0] exp);
    bus.addr = a;
    #1;
    check(tag, bus.dout, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic exp_irq;
    n_total  = 0;
    n_bad    = 0;
    reset    = 1'b1;
    bus.addr = 2'd0;
    bus.we   = 1'b0;
    bus.din  = '0;
    tickn(2);
    reset = 1'b0;

    // Reset values
    rd_chk("rst_ctrl", 2'd0, 32'h0);
    rd_chk("rst_preset", 2'd1, 32'h0);
    rd_chk("rst_count", 2'd2, 32'h0);
    rd_chk("rst_addr3", 2'd3, 32'h0);
    check("rst_irq", {31'b0, irq}, 32'h0);

    // One-shot, P=5: irq rises at t+7 and holds
    wr(2'd1, 32'd5);
    wr(2'd0, 32'h9);
    tickn(2);
    rd_chk("os_count_load", 2'd2, 32'd5);
    tickn(4);
    check("os_irq_t6", {31'b0, irq}, 32'h0);
    tick();
    check("os_irq_t7", {31'b0, irq}, 32'h1);
    rd_chk("os_count_t7", 2'd2, 32'h0);
    tick();
    check("os_irq_held", {31'b0, irq}, 32'h1);
    rd_chk("os_ctrl_en_clr", 2'd0, 32'h8);
    wr(2'd0, 32'h0);
    check("os_irq_clr", {31'b0, irq}, 32'h0);
    tickn(2);

    // MODE 1, P=3: pulse every 5 cycles (or a held irq when reload is absent)
    wr(2'd1, 32'd3);
    wr(2'd0, 32'hB);
    for (int k = 1; k <= 16; k++) begin
      tick();
`ifdef TIMER_AUTORELOAD_EN
      exp_irq = (k % 5 == 0);
`else
      exp_irq = (k >= 5);
`endif
      check($sformatf("m1_irq_k%0d", k), {31'b0, irq}, {31'b0, exp_irq});
    end
`ifdef TIMER_AUTORELOAD_EN
    rd_chk("m1_ctrl", 2'd0, 32'hB);
`else
    rd_chk("m1_ctrl", 2'd0, 32'h8);
`endif
    wr(2'd0, 32'h0);
    tickn(4);
    check("m1_irq_off", {31'b0, irq}, 32'h0);

    // PRESET write mid-count only affects the next LOAD
    wr(2'd1, 32'd10);
    wr(2'd0, 32'hB);
    tickn(2);
    rd_chk("pw_count_load", 2'd2, 32'd10);
    wr(2'd1, 32'd2);
    tickn(8);
    check("pw_irq_k11", {31'b0, irq}, 32'h0);
    rd_chk("pw_count_k11", 2'd2, 32'd1);
    tick();
    check("pw_irq_k12", {31'b0, irq}, 32'h1);
`ifdef TIMER_AUTORELOAD_EN
    tick();
    check("pw_irq_k13", {31'b0, irq}, 32'h0);
    tick();
    rd_chk("pw_count_reload", 2'd2, 32'd2);
    tick();
    check("pw_irq_k15", {31'b0, irq}, 32'h0);
    tick();
    check("pw_irq_k16", {31'b0, irq}, 32'h1);
`else
    tick();
    rd_chk("pw_ctrl_k13", 2'd0, 32'h8);
    wr(2'd0, 32'h9);
    check("pw_irq_rearm", {31'b0, irq}, 32'h0);
    tickn(3);
    check("pw_irq_u3", {31'b0, irq}, 32'h0);
    tick();
    check("pw_irq_u4", {31'b0, irq}, 32'h1);
`endif
    wr(2'd0, 32'h0);
    tickn(4);

    // PRESET 0, IM=0: expiry after 3 cycles without irq; CTRL write clears flag
    wr(2'd1, 32'd0);
    wr(2'd0, 32'h1);
    tickn(3);
    check("p0_irq_t3", {31'b0, irq}, 32'h0);
    rd_chk("p0_ctrl_t3", 2'd0, 32'h1);
    tick();
    rd_chk("p0_ctrl_t4", 2'd0, 32'h0);
    wr(2'd0, 32'h8);
    check("p0_irq_im_set", {31'b0, irq}, 32'h0);
    tick();
    check("p0_irq_later", {31'b0, irq}, 32'h0);
    wr(2'd0, 32'h0);

    // Reset mid-count
    wr(2'd1, 32'd6);
    wr(2'd0, 32'h1);
    tickn(4);
    rd_chk("mr_count4", 2'd2, 32'd4);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    rd_chk("mr_ctrl", 2'd0, 32'h0);
    rd_chk("mr_preset", 2'd1, 32'h0);
    rd_chk("mr_count", 2'd2, 32'h0);
    check("mr_irq", {31'b0, irq}, 32'h0);
    tickn(3);
    rd_chk("mr_idle_count", 2'd2, 32'h0);
    wr(2'd2, 32'hFFFF);
    rd_chk("cw_idle_ignored", 2'd2, 32'h0);

    // COUNT write while running is ignored; addr 3 and CTRL upper bits
    wr(2'd1, 32'd7);
    wr(2'd0, 32'h1);
    tickn(2);
    rd_chk("cw_count7", 2'd2, 32'd7);
    wr(2'd2, 32'hFFFF);
    rd_chk("cw_run_ignored", 2'd2, 32'd6);
    wr(2'd3, 32'h1234);
    rd_chk("a3_read", 2'd3, 32'h0);
    wr(2'd0, 32'hFFFF_FFF8);
    rd_chk("ctrl_upper", 2'd0, 32'h8);
    tickn(2);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/timer_dev.md
# timer_dev

Memory-mapped countdown timer that sits on the CPU's peripheral bus as a responder to the pipeline's load/store accesses. The CPU writes control and preset words; the block counts down and raises an interrupt request toward CP0. Load data it returns is selected into the W-stage writeback path alongside data-memory and CP0 read data.

## Interface
Parameters:
- none; width is the codebase-wide 32-bit word (`F).

Ports:
- clk  in  1  rising-edge clock, the single clock of the block.
- reset  in  1  synchronous, active-high reset.
- addr  in  2  word offset, CPU address bits [3:2]: 0 = CTRL, 1 = PRESET, 2 = COUNT, 3 = unmapped.
- we  in  1  write strobe for the addressed register, sampled at the clock edge.
- din  in  32  write data.
- dout  out  32  read data for `addr`, combinational.
- irq  out  1  interrupt request to CP0, registered.

## Operation
- CTRL: [0] EN, [2:1] MODE, [3] IM (interrupt mask); bits [31:4] read as 0 and ignore writes.
- PRESET: full 32-bit read/write reload value.
- COUNT: read-only current count; writes are ignored.
- addr 3 reads 0; writes to it are ignored.
- MODE 0 is one-shot. MODE 1 is auto-reload. MODE values 2 and 3 behave as MODE 0.
- `irq` = irq_flag & IM.
- FSM states: IDLE, LOAD, CNT, INT.
  - IDLE: if EN, go to LOAD.
  - LOAD: COUNT <= PRESET; go to CNT.
  - CNT: if !EN, go to IDLE and hold COUNT. If COUNT > 1, decrement COUNT. Otherwise, COUNT <= 0, set irq_flag, and go to INT.
  - INT, MODE 0: clear EN and go to IDLE. irq_flag stays set until any CTRL write.
  - INT, MODE 1: clear irq_flag and go to LOAD. irq is a one-cycle pulse.
- Unsigned arithmetic with no wrap. PRESET 0 and PRESET 1 both spend one cycle in CNT.
- A PRESET write during CNT does not affect the running count; it takes effect on the next LOAD.
- Simultaneous events:
  - A CPU CTRL write in the same cycle as the INT-state EN clear: the CPU write wins.
  - A CTRL write clears irq_flag unless the same edge is the CNT→INT transition; in that case the flag is set.

## Timing
- Reset values: CTRL = 0, PRESET = 0, COUNT = 0, irq_flag = 0, state IDLE, irq = 0, dout = 0 for every readable address.
- Reset asserted mid-count returns everything to reset values at that edge.
- With EN written at edge t and PRESET = P ≥ 1:
  - edge t+1: LOAD.
  - edge t+2: COUNT = P.
  - edge t+2+P: COUNT = 0 and irq rises.
- MODE 1 period: P+2 cycles between successive irq pulses.
- Write-to-read latency: a register written at edge t reads back the new value in the cycle after t.
- `dout` has no added latency relative to `addr`.

## Configuration
- TIMER_AUTORELOAD_EN
  - Defined: MODE 1 auto-reload behaves as described.
  - Undefined: MODE bits are not stored and read as 0, and every expiry behaves as MODE 0. Both the FSM and the irq_flag clear path use this one-shot behaviour.

## Structure
- Shared header/package holds:
  - register offsets (CTRL, PRESET, COUNT)
  - CTRL bit positions (EN, MODE, IM)
  - mode encodings
  - FSM state encodings
  - the word-width macro
- Single flat module. The register file and FSM are tightly coupled, so no sub-module is warranted.

## Test plan
- Reset, then read addr 0/1/2/3 -> dout = 0 for all; irq = 0.
- PRESET = 5, CTRL = 0x9 (EN, IM, MODE 0) -> irq rises at edge t+7 and stays high. COUNT = 0 and EN = 0 on readback. A later CTRL write of 0 drops irq the next cycle.
- PRESET = 3, CTRL = 0xB (EN, MODE 1, IM), with TIMER_AUTORELOAD_EN defined -> irq pulses high for one cycle every 5 cycles. The same test with the macro undefined -> a single held irq, and CTRL reads 0x8 after expiry.
- During a count from PRESET = 10, write PRESET = 2 -> the current run still takes 10 CNT cycles; the MODE 1 reload uses 2.
- PRESET = 0, CTRL = 0x1 (IM = 0) -> internal expiry after 3 cycles with irq held at 0. A following CTRL write of 0x8 -> irq stays 0, because that write also clears irq_flag.
- Assert reset with COUNT = 4 in CNT -> the next cycle shows IDLE, all registers 0, and irq = 0. A write to COUNT (addr 2, din = 0xFFFF) leaves COUNT unchanged.
